quick_spi_slave: RTL and testbench
==================================

Name: quick_spi_slave

Overview:
SPI responder (slave) that sits at the peripheral end of the link driven by the team's SPI master. It runs entirely in the system clock domain and oversamples the synchronized sclk, ss_n and mosi lines. It captures one RX word per frame and shifts out one preloaded TX word on miso. Host logic loads TX data and receives RX data through a simple ready/valid interface.

Parameters:
RX_DATA_WIDTH, 16, bits captured from mosi per frame
TX_DATA_WIDTH, 8, bits driven on miso per frame
CPOL, 0, sclk idle level
CPHA, 0, 0 = sample on leading edge / shift on trailing; 1 = shift on leading / sample on trailing
SYNC_STAGES, 2, synchronizer depth for sclk, ss_n and mosi (min 2)

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
enable  input  1  block enable; low = ignore/abort frames
sclk  input  1  SPI clock from master
ss_n  input  1  slave select, active low
mosi  input  1  serial data from master
miso  output  1  serial data to master
miso_oe  output  1  miso output enable, for the top-level tri-state
tx_data  input  TX_DATA_WIDTH  word to send in the next frame
tx_load  input  1  capture tx_data when tx_ready=1
tx_ready  output  1  TX holding register empty
rx_data  output  RX_DATA_WIDTH  last complete received word
rx_valid  output  1  1-cycle pulse when rx_data updates
frame_error  output  1  1-cycle pulse when ss_n rises before RX_DATA_WIDTH bits
busy  output  1  high in ACTIVE

Behaviour:
- Reset is clk and reset_n, synchronous, active-low.
- Reset values: miso=0, miso_oe=0, rx_data=0, rx_valid=0, frame_error=0, tx_ready=1, busy=0, bit counters=0. The holding register and shift registers are cleared.
- sclk, ss_n and mosi each pass through SYNC_STAGES flops. The synchronizers reset to CPOL, 1 and 0.
- Edges are detected on synchronized sclk. Leading edge = transition away from CPOL. Trailing edge = transition back to CPOL.
- Supported sclk frequency is at most clk/8.
- Bit order is LSB first. The first mosi bit lands in rx bit 0. tx bit 0 is driven first. Byte ordering is the host's responsibility.
- States:
  - IDLE: waiting for a frame. The FSM moves to ACTIVE when enable=1 and synchronized ss_n transitions 1->0. On that cycle:
    - The TX holding register (or zeros if tx_ready=1) moves to the TX shift register.
    - tx_ready goes to 1.
    - The bit counters clear.
    - miso_oe and busy go to 1.
    - If CPHA=0, miso takes tx bit 0.
  - ACTIVE:
    - Sample edge (leading if CPHA=0, trailing if CPHA=1): while rx_count < RX_DATA_WIDTH, shift synchronized mosi in and increment rx_count. On the cycle rx_count reaches RX_DATA_WIDTH, rx_data is loaded and rx_valid pulses for 1 cycle. Later sample edges are ignored.
    - Shift edge, CPHA=0 (trailing): advance to the next tx bit.
    - Shift edge, CPHA=1 (leading): present the next tx bit; the first leading edge presents bit 0.
    - Once TX_DATA_WIDTH bits have been presented, further shift edges drive miso=0.
    - On a synchronized ss_n 0->1 transition: move to IDLE, set miso_oe=0, miso=0, busy=0. If rx_count < RX_DATA_WIDTH, pulse frame_error and leave rx_data unchanged.
  - WAIT_DESELECT: entered on reset release or on enable going low while ss_n is low. Nothing is captured or driven (miso_oe=0). The FSM moves to IDLE when synchronized ss_n=1. This guarantees no partial frame is ever accepted.
- enable low in ACTIVE: abort immediately to WAIT_DESELECT (or IDLE if ss_n=1). No rx_valid and no frame_error. The TX word consumed by the aborted frame is lost.
- tx handshake:
  - tx_load with tx_ready=1 captures tx_data and drops tx_ready to 0.
  - tx_load with tx_ready=0 is ignored; the holding register is unchanged.
  - tx_load may occur in any state. A load during ACTIVE is used for the next frame.
  - tx_load on the same cycle as frame start: the frame consumes the old content (or zeros), the new word is captured, and tx_ready ends at 0.
- Simultaneous final sample edge and ss_n rise in the same clk cycle (possible only when clk/sclk ratio is violated): the sample is taken first and rx_valid pulses; no frame_error.
- Latency: rx_valid is asserted 1 clk after the synchronized final sample edge, i.e. SYNC_STAGES+2 clk after the raw sclk edge.

Test Plan:
- CPOL=0, CPHA=0. Preload tx_data=8'hA5, then a 16-bit frame with mosi word 16'h3C5A (LSB first). Required: miso bits 1,0,1,0,0,1,0,1 then 0s; rx_data=16'h3C5A; one rx_valid pulse; frame_error stays 0; tx_ready back to 1 at frame start.
- All four CPOL/CPHA combinations with tx=8'h81 and rx=16'hFFFE. Required: correct sample/shift edges; rx_data=16'hFFFE; miso first bit 1, last bit 1.
- Frame with no preceding tx_load. Required: miso all 0; miso_oe=1 only while ss_n is low.
- ss_n raised after 9 sclk cycles. Required: frame_error pulses once; rx_valid stays 0; rx_data keeps its previous value 16'h3C5A.
- tx_load with 8'h11, then a second tx_load with 8'h22 while tx_ready=0, then a frame. Required: 8'h11 is transmitted.
- Reset asserted and enable dropped mid-frame, each with ss_n still low. Required: outputs at reset values; remaining sclk edges ignored; no rx_valid. The next full frame after ss_n goes high is received correctly.

Source files
------------

// File: rtl/quick_spi_slave.sv
// SPI responder oversampling sclk/ss_n/mosi in the clk domain; LSB-first,
// one RX word captured and one preloaded TX word shifted out per frame.
module quick_spi_slave #(
  parameter int unsigned RX_DATA_WIDTH = 16,
  parameter int unsigned TX_DATA_WIDTH = 8,
  parameter int unsigned CPOL          = 0,
  parameter int unsigned CPHA          = 0,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     sclk,
  input  logic                     ss_n,
  input  logic                     mosi,
  output logic                     miso,
  output logic                     miso_oe,
  input  logic [TX_DATA_WIDTH-1:0] tx_data,
  input  logic                     tx_load,
  output logic                     tx_ready,
  output logic [RX_DATA_WIDTH-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     frame_error,
  output logic                     busy
);

  localparam logic IDLE_LVL = (CPOL != 0);
  localparam logic CPHA1    = (CPHA != 0);
  localparam int unsigned RXC_W = $clog2(RX_DATA_WIDTH + 1);
  localparam int unsigned TXC_W = $clog2(TX_DATA_WIDTH + 1);
  localparam int unsigned FL_W  = $clog2(SYNC_STAGES + 3);
  localparam logic [RXC_W-1:0] RX_FULL    = RXC_W'(RX_DATA_WIDTH);
  localparam logic [RXC_W-1:0] RX_LAST    = RXC_W'(RX_DATA_WIDTH - 1);
  localparam logic [TXC_W-1:0] TX_FULL    = TXC_W'(TX_DATA_WIDTH);
  localparam logic [FL_W-1:0]  FLUSH_DONE = FL_W'(SYNC_STAGES + 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_d, ss_d;
  logic lead_q, trail_q, ss_fall_q, ss_rise_q, mosi_q;
  logic sample_q, shift_q;

  logic [FL_W-1:0]          flush_cnt;
  logic                     settled;
  logic [TX_DATA_WIDTH-1:0] tx_hold, tx_shift, tx_word;
  logic [TXC_W-1:0]         tx_count;
  logic [RX_DATA_WIDTH-1:0] rx_shift, rx_next;
  logic [RXC_W-1:0]         rx_count;

  logic start_frame, do_sample, do_shift, set_ferr, leave_active;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_sync <= {SYNC_STAGES{IDLE_LVL}};
      ss_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edge strobes are registered; mosi_q is delayed alongside to stay aligned.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_d    <= IDLE_LVL;
      ss_d      <= 1'b1;
      lead_q    <= 1'b0;
      trail_q   <= 1'b0;
      ss_fall_q <= 1'b0;
      ss_rise_q <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
      lead_q    <= (sclk_s != sclk_d) && (sclk_s != IDLE_LVL);
      trail_q   <= (sclk_s != sclk_d) && (sclk_s == IDLE_LVL);
      ss_fall_q <= ss_d & ~ss_s;
      ss_rise_q <= ~ss_d & ss_s;
      mosi_q    <= mosi_s;
    end
  end

  assign sample_q = CPHA1 ? trail_q : lead_q;
  assign shift_q  = CPHA1 ? lead_q  : trail_q;

  // The ss_n chain resets to 1; hold off leaving WAIT until it reflects the pin.
  always_ff @(posedge clk) begin
    if (!reset_n)
      flush_cnt <= '0;
    else if (flush_cnt != FLUSH_DONE)
      flush_cnt <= flush_cnt + 1'b1;
  end

  assign settled = (flush_cnt == FLUSH_DONE);

  always_ff @(posedge clk) begin
    if (!reset_n)
      state <= ST_WAIT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    do_sample   = 1'b0;
    do_shift    = 1'b0;
    set_ferr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!enable) begin
          if (!ss_d)
            state_nxt = ST_WAIT;
        end else if (ss_fall_q) begin
          state_nxt   = ST_ACTIVE;
          start_frame = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!enable) begin
          state_nxt = ss_d ? ST_IDLE : ST_WAIT;
        end else begin
          do_sample = sample_q && (rx_count < RX_FULL);
          do_shift  = shift_q;
          if (ss_rise_q) begin
            state_nxt = ST_IDLE;
            set_ferr  = !((rx_count == RX_FULL) ||
                          (do_sample && (rx_count == RX_LAST)));
          end
        end
      end
      ST_WAIT: begin
        if (settled && ss_d)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

  assign leave_active = (state == ST_ACTIVE) && (state_nxt != ST_ACTIVE);
  assign busy         = (state == ST_ACTIVE);
  assign miso_oe      = (state == ST_ACTIVE);
  assign tx_word      = tx_ready ? '0 : tx_hold;
  assign rx_next      = {mosi_q, rx_shift[RX_DATA_WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_hold     <= '0;
      tx_ready    <= 1'b1;
      tx_shift    <= '0;
      tx_count    <= '0;
      rx_shift    <= '0;
      rx_count    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      miso        <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      frame_error <= set_ferr;

      if (start_frame)
        tx_ready <= 1'b1;
      // A frame start empties the holding register, so a same-cycle load lands.
      if (tx_load && (tx_ready || start_frame)) begin
        tx_hold  <= tx_data;
        tx_ready <= 1'b0;
      end

      if (start_frame) begin
        rx_shift <= '0;
        rx_count <= '0;
        if (CPHA1) begin
          tx_shift <= tx_word;
          tx_count <= '0;
        end else begin
          miso     <= tx_word[0];
          tx_shift <= tx_word >> 1;
          tx_count <= TXC_W'(1);
        end
      end

      if (do_sample) begin
        rx_shift <= rx_next;
        rx_count <= rx_count + 1'b1;
        if (rx_count == RX_LAST) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end
      end

      if (do_shift) begin
        if (tx_count < TX_FULL) begin
          miso     <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
          tx_count <= tx_count + 1'b1;
        end else begin
          miso <= 1'b0;
        end
      end

      if (leave_active)
        miso <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quick_spi_slave.sv
// Directed bench for quick_spi_slave: one instance per CPOL/CPHA mode,
// driven by a bit-banged SPI master running at clk/16.
module tb_quick_spi_slave;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [3:0]  sclk;
  logic [3:0]  ss_n;
  logic        mosi;
  logic [3:0]  miso;
  logic [3:0]  miso_oe;
  logic [7:0]  tx_data;
  logic [3:0]  tx_load;
  logic [3:0]  tx_ready;
  logic [15:0] rx_data [4];
  logic [3:0]  rx_valid;
  logic [3:0]  frame_error;
  logic [3:0]  busy;

  int n_vec = 0;
  int n_err = 0;
  int rxv_cnt [4] = '{0, 0, 0, 0};
  int fe_cnt  [4] = '{0, 0, 0, 0};
  logic oe_mid, rdy_mid;

  // Instance g runs with CPOL = g/2, CPHA = g%2.
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      quick_spi_slave #(
        .RX_DATA_WIDTH(16),
        .TX_DATA_WIDTH(8),
        .CPOL(g / 2),
        .CPHA(g % 2),
        .SYNC_STAGES(2)
      ) u_dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .sclk(sclk[g]),
        .ss_n(ss_n[g]),
        .mosi(mosi),
        .miso(miso[g]),
        .miso_oe(miso_oe[g]),
        .tx_data(tx_data),
        .tx_load(tx_load[g]),
        .tx_ready(tx_ready[g]),
        .rx_data(rx_data[g]),
        .rx_valid(rx_valid[g]),
        .frame_error(frame_error[g]),
        .busy(busy[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rx_valid[k])    rxv_cnt[k]++;
      if (frame_error[k]) fe_cnt[k]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tx_push(input int m, input logic [7:0] d);
    tx_data    = d;
    tx_load[m] = 1'b1;
    @(negedge clk);
    tx_load[m] = 1'b0;
  endtask

  // Master side of one frame; cap[i] is the miso bit sampled for bit i.
  task automatic spi_frame(input int m, input int nbits, input logic [15:0] word,
                           input bit drop_ss, input bit raise_ss,
                           output logic [15:0] cap);
    bit cpol, cpha;
    cpol = ((m >> 1) & 1) != 0;
    cpha = (m & 1) != 0;
    cap  = '0;
    if (drop_ss) begin
      ss_n[m] = 1'b0;
      if (!cpha) mosi = word[0];
      repeat (8) @(negedge clk);
    end
    for (int i = 0; i < nbits; i++) begin
      sclk[m] = ~cpol;
      if (cpha) mosi = word[i];
      else      cap[i] = miso[m];
      if (i == 0) begin
        oe_mid  = miso_oe[m];
        rdy_mid = tx_ready[m];
      end
      repeat (8) @(negedge clk);
      sclk[m] = cpol;
      if (cpha)        cap[i] = miso[m];
      else if (i < 15) mosi = word[i+1];
      repeat (8) @(negedge clk);
    end
    if (raise_ss) begin
      ss_n[m] = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] cap;
    int r0, f0;

    reset_n = 1'b0;
    enable  = 1'b1;
    sclk    = 4'b1100;
    ss_n    = '1;
    mosi    = 1'b0;
    tx_load = '0;
    tx_data = '0;
    repeat (4) @(negedge clk);
    check("rst_miso",     miso[0],        0);
    check("rst_miso_oe",  miso_oe[0],     0);
    check("rst_busy",     busy[0],        0);
    check("rst_rx_data",  rx_data[0],     0);
    check("rst_rx_valid", rx_valid[0],    0);
    check("rst_ferr",     frame_error[0], 0);
    check("rst_tx_ready", tx_ready[0],    1);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Frame with empty holding register sends zeros.
    r0 = rxv_cnt[0];
    spi_frame(0, 16, 16'h0F0F, 1, 1, cap);
    check("noload_miso",   cap, 16'h0000);
    check("noload_oe_mid", oe_mid, 1);
    check("noload_oe_end", miso_oe[0], 0);
    check("noload_rx",     rx_data[0], 16'h0F0F);
    check("noload_rxv",    rxv_cnt[0] - r0, 1);

    // Basic frame: tx A5, rx 3C5A.
    tx_push(0, 8'hA5);
    check("a5_tx_ready_low", tx_ready[0], 0);
    r0 = rxv_cnt[0]; f0 = fe_cnt[0];
    spi_frame(0, 16, 16'h3C5A, 1, 1, cap);
    check("a5_miso",     cap, 16'h00A5);
    check("a5_rdy_mid",  rdy_mid, 1);
    check("a5_rx",       rx_data[0], 16'h3C5A);
    check("a5_rxv",      rxv_cnt[0] - r0, 1);
    check("a5_ferr",     fe_cnt[0] - f0, 0);

    // Short frame: 9 bits then deselect.
    r0 = rxv_cnt[0]; f0 = fe_cnt[0];
    spi_frame(0, 9, 16'hFFFF, 1, 1, cap);
    check("short_ferr", fe_cnt[0] - f0, 1);
    check("short_rxv",  rxv_cnt[0] - r0, 0);
    check("short_rx",   rx_data[0], 16'h3C5A);
    check("short_busy", busy[0], 0);

    // Second load while not ready is dropped.
    tx_push(0, 8'h11);
    tx_push(0, 8'h22);
    check("dbl_tx_ready", tx_ready[0], 0);
    spi_frame(0, 16, 16'h0001, 1, 1, cap);
    check("dbl_miso", cap, 16'h0011);
    check("dbl_rx",   rx_data[0], 16'h0001);

    // All four CPOL/CPHA modes.
    for (int m = 0; m < 4; m++) begin
      tx_push(m, 8'h81);
      r0 = rxv_cnt[m]; f0 = fe_cnt[m];
      spi_frame(m, 16, 16'hFFFE, 1, 1, cap);
      check($sformatf("mode%0d_rx", m),   rx_data[m], 16'hFFFE);
      check($sformatf("mode%0d_miso", m), cap, 16'h0081);
      check($sformatf("mode%0d_rxv", m),  rxv_cnt[m] - r0, 1);
      check($sformatf("mode%0d_ferr", m), fe_cnt[m] - f0, 0);
    end

    // Reset mid-frame with ss_n held low.
    spi_frame(0, 5, 16'hAAAA, 1, 0, cap);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mrst_miso",     miso[0],     0);
    check("mrst_oe",       miso_oe[0],  0);
    check("mrst_busy",     busy[0],     0);
    check("mrst_rx_data",  rx_data[0],  0);
    check("mrst_tx_ready", tx_ready[0], 1);
    r0 = rxv_cnt[0]; f0 = fe_cnt[0];
    spi_frame(0, 11, 16'h5555, 0, 1, cap);
    check("mrst_tail_oe",   oe_mid, 0);
    check("mrst_tail_rxv",  rxv_cnt[0] - r0, 0);
    check("mrst_tail_ferr", fe_cnt[0] - f0, 0);
    tx_push(0, 8'hC3);
    r0 = rxv_cnt[0];
    spi_frame(0, 16, 16'hBEEF, 1, 1, cap);
    check("mrst_next_miso", cap, 16'h00C3);
    check("mrst_next_rx",   rx_data[0], 16'hBEEF);
    check("mrst_next_rxv",  rxv_cnt[0] - r0, 1);

    // Enable drop mid-frame; the consumed TX word is lost.
    tx_push(0, 8'h3C);
    r0 = rxv_cnt[0]; f0 = fe_cnt[0];
    spi_frame(0, 5, 16'hAAAA, 1, 0, cap);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy", busy[0],    0);
    check("abort_oe",   miso_oe[0], 0);
    enable = 1'b1;
    spi_frame(0, 11, 16'h5555, 0, 1, cap);
    check("abort_tail_oe", oe_mid, 0);
    check("abort_rxv",     rxv_cnt[0] - r0, 0);
    check("abort_ferr",    fe_cnt[0] - f0, 0);
    check("abort_rx_kept", rx_data[0], 16'hBEEF);
    r0 = rxv_cnt[0];
    spi_frame(0, 16, 16'h1357, 1, 1, cap);
    check("abort_next_miso", cap, 16'h0000);
    check("abort_next_rx",   rx_data[0], 16'h1357);
    check("abort_next_rxv",  rxv_cnt[0] - r0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
